// File: rtl/dphy_hs_lane_seq_if.sv
// Upstream payload stream into the D-PHY HS lane sequencer: burst request plus valid/ready byte channel.
interface dphy_hs_lane_seq_if;
    logic       req;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (output req, output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input req, input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/dphy_hs_lane_seq.sv
// Per-lane D-PHY HS burst sequencer (LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11).
// Optional burst/underrun statistics counters are built when DPHY_SEQ_STATS_EN is defined.
module dphy_hs_lane_seq #(
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 3,
    parameter int unsigned T_HS_ZERO    = 8,
    parameter int unsigned T_HS_TRAIL   = 4,
    parameter int unsigned T_HS_EXIT    = 4,
    parameter int unsigned TMR_W        = 8
) (
    input  logic                byte_clk,
    input  logic                rst_n,
    dphy_hs_lane_seq_if.slave   up,
    output logic [7:0]          hs_data,
    output logic                hs_en,
    output logic                lp_p,
    output logic                lp_n,
    output logic                busy,
    output logic                done,
    output logic                underrun
`ifdef DPHY_SEQ_STATS_EN
    ,
    output logic [15:0]         stat_bursts,
    output logic [7:0]          stat_underruns
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LP01  = 3'd1;
    localparam logic [2:0] S_LP00  = 3'd2;
    localparam logic [2:0] S_ZERO  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_TRAIL = 3'd5;
    localparam logic [2:0] S_EXIT  = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    logic [2:0]       state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [7:0]       hs_data_nx;
    logic             last_bit, last_bit_nx;
    logic             done_nx, underrun_nx;
    logic             lp_p_nx, lp_n_nx, hs_en_nx, busy_nx;
    logic             tmr_zero;

    // The sync byte is on the lane during the first DATA cycle, so the first payload
    // byte is taken while 0xB8 is being sent and no filler byte is ever emitted.
    assign up.in_ready = (state == S_DATA);
    assign tmr_zero    = (timer == '0);

    // Next-state, timer and registered-output decode
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        hs_data_nx  = hs_data;
        last_bit_nx = last_bit;
        done_nx     = 1'b0;
        underrun_nx = 1'b0;

        case (state)
            S_IDLE: begin
                hs_data_nx = 8'h00;
                if (up.req) begin
                    state_nx = S_LP01;
                    timer_nx = TMR_W'(T_LPX - 1);
                end
            end
            S_LP01: begin
                if (tmr_zero) begin
                    state_nx = S_LP00;
                    timer_nx = TMR_W'(T_HS_PREPARE - 1);
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_LP00: begin
                if (tmr_zero) begin
                    state_nx = S_ZERO;
                    timer_nx = TMR_W'(T_HS_ZERO - 1);
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_ZERO: begin
                if (tmr_zero) begin
                    state_nx    = S_DATA;
                    hs_data_nx  = SYNC_BYTE;
                    last_bit_nx = SYNC_BYTE[7];
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_DATA: begin
                if (up.in_valid) begin
                    hs_data_nx  = up.in_data;
                    last_bit_nx = up.in_data[7];
                    if (up.in_last) begin
                        // last byte still occupies one lane cycle before the trail pattern
                        state_nx = S_TRAIL;
                        timer_nx = TMR_W'(T_HS_TRAIL);
                    end
                end else begin
                    state_nx    = S_TRAIL;
                    timer_nx    = TMR_W'(T_HS_TRAIL - 1);
                    hs_data_nx  = {8{~last_bit}};
                    underrun_nx = 1'b1;
                end
            end
            S_TRAIL: begin
                hs_data_nx = {8{~last_bit}};
                if (tmr_zero) begin
                    state_nx   = S_EXIT;
                    timer_nx   = TMR_W'(T_HS_EXIT - 1);
                    hs_data_nx = 8'h00;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            S_EXIT: begin
                if (tmr_zero) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            default: begin
                state_nx   = S_IDLE;
                timer_nx   = '0;
                hs_data_nx = 8'h00;
            end
        endcase

        lp_p_nx  = (state_nx == S_IDLE) || (state_nx == S_EXIT);
        lp_n_nx  = (state_nx == S_IDLE) || (state_nx == S_EXIT) || (state_nx == S_LP01);
        hs_en_nx = (state_nx == S_ZERO) || (state_nx == S_DATA) || (state_nx == S_TRAIL);
        busy_nx  = (state_nx != S_IDLE);
    end

    // State, timer and lane pins; reset returns the lane to LP-11 without a trail
    always_ff @(posedge byte_clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            last_bit <= 1'b0;
            hs_data  <= 8'h00;
            hs_en    <= 1'b0;
            lp_p     <= 1'b1;
            lp_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            last_bit <= last_bit_nx;
            hs_data  <= hs_data_nx;
            hs_en    <= hs_en_nx;
            lp_p     <= lp_p_nx;
            lp_n     <= lp_n_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            underrun <= underrun_nx;
        end
    end

`ifdef DPHY_SEQ_STATS_EN
    // Saturating event counters, advanced on the same edge that raises each pulse
    always_ff @(posedge byte_clk) begin
        if (!rst_n) begin
            stat_bursts    <= 16'h0000;
            stat_underruns <= 8'h00;
        end else begin
            if (done_nx && (stat_bursts != 16'hFFFF)) begin
                stat_bursts <= stat_bursts + 16'd1;
            end
            if (underrun_nx && (stat_underruns != 8'hFF)) begin
                stat_underruns <= stat_underruns + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dphy_hs_lane_seq.sv
// Bench for dphy_hs_lane_seq: per-cycle pin traces derived from burst descriptions, random payloads and underruns.
module tb_dphy_hs_lane_seq;

    localparam int unsigned T_LPX        = 2;
    localparam int unsigned T_HS_PREPARE = 3;
    localparam int unsigned T_HS_ZERO    = 4;
    localparam int unsigned T_HS_TRAIL   = 3;
    localparam int unsigned T_HS_EXIT    = 2;

    logic       byte_clk = 1'b0;
    logic       rst_n;
    logic [7:0] hs_data;
    logic       hs_en, lp_p, lp_n, busy, done, underrun;
`ifdef DPHY_SEQ_STATS_EN
    logic [15:0] stat_bursts;
    logic [7:0]  stat_underruns;
`endif

    dphy_hs_lane_seq_if up_if ();

    dphy_hs_lane_seq #(
        .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE), .T_HS_ZERO(T_HS_ZERO),
        .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT), .TMR_W(8)
    ) dut (
        .byte_clk(byte_clk), .rst_n(rst_n), .up(up_if),
        .hs_data(hs_data), .hs_en(hs_en), .lp_p(lp_p), .lp_n(lp_n),
        .busy(busy), .done(done), .underrun(underrun)
`ifdef DPHY_SEQ_STATS_EN
        , .stat_bursts(stat_bursts), .stat_underruns(stat_underruns)
`endif
    );

    always #5 byte_clk = ~byte_clk;

    typedef struct packed {
        logic       lp_p;
        logic       lp_n;
        logic       hs_en;
        logic [7:0] hs_data;
        logic       busy;
        logic       done;
        logic       underrun;
        logic       in_ready;
    } obs_t;

    obs_t       q[$];
    logic [7:0] pay[$];
    int         n_take;
    bit         urun;
    int         idx;
    int         burst_no = 0;
    int         total = 0;
    int         bad = 0;
    int         exp_bursts = 0;
    int         exp_unders = 0;

    function automatic obs_t mk(input logic lp, input logic ln, input logic he, input logic [7:0] d,
                                input logic bz, input logic dn, input logic ur, input logic rd);
        obs_t o;
        o.lp_p = lp; o.lp_n = ln; o.hs_en = he; o.hs_data = d;
        o.busy = bz; o.done = dn; o.underrun = ur; o.in_ready = rd;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(lp_p, lp_n, hs_en, hs_data, busy, done, underrun, up_if.in_ready);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected lane trace from the cycle after req is taken up to the done cycle
    task automatic build();
        logic [7:0] last;
        q.delete();
        repeat (T_LPX)        q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (T_HS_PREPARE) q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (T_HS_ZERO)    q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b0, 1'b0, 1'b1));
        last = 8'hB8;
        for (int i = 0; i < n_take; i++) begin
            q.push_back(mk(1'b0, 1'b0, 1'b1, pay[i], 1'b1, 1'b0, 1'b0, urun || (i < n_take - 1)));
            last = pay[i];
        end
        for (int i = 0; i < int'(T_HS_TRAIL); i++)
            q.push_back(mk(1'b0, 1'b0, 1'b1, {8{~last[7]}}, 1'b1, 1'b0, urun && (i == 0), 1'b0));
        repeat (T_HS_EXIT)    q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    // Source side: offer bytes until the planned count is taken, junk otherwise
    task automatic drive();
        if (idx < n_take) begin
            up_if.in_valid = 1'b1;
            up_if.in_data  = pay[idx];
            up_if.in_last  = !urun && (idx == n_take - 1);
        end else begin
            up_if.in_valid = 1'b0;
            up_if.in_data  = 8'($urandom);
            up_if.in_last  = 1'($urandom);
        end
        if (up_if.in_valid && up_if.in_ready) idx++;
    endtask

    // Entered at a negedge of an IDLE cycle; leaves at the negedge of the done cycle
    task automatic run_burst(input int abort_at);
        build();
        idx = 0;
        up_if.req = 1'b1;
        drive();
        for (int c = 0; c < q.size(); c++) begin
            @(negedge byte_clk);
            chk($sformatf("burst%0d_cyc%0d", burst_no, c), 32'(sample()), 32'(q[c]));
            if (c == abort_at) begin
                rst_n = 1'b0;
                up_if.req = 1'b0;
                up_if.in_valid = 1'b0;
                burst_no++;
                return;
            end
            up_if.req = (c < q.size() - 1) ? 1'($urandom) : 1'b0;
            drive();
        end
        exp_bursts++;
        if (urun) exp_unders++;
        burst_no++;
    endtask

    task automatic idle_cycles(input int n);
        up_if.req = 1'b0;
        for (int i = 0; i < n; i++) begin
            up_if.in_valid = 1'($urandom);
            up_if.in_data  = 8'($urandom);
            up_if.in_last  = 1'($urandom);
            @(negedge byte_clk);
            chk($sformatf("idle_b%0d_%0d", burst_no, i), 32'(sample()),
                32'(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        up_if.req      = 1'b1;
        up_if.in_valid = 1'b1;
        up_if.in_data  = 8'h5A;
        up_if.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge byte_clk);
            chk($sformatf("reset_%0d", i), 32'(sample()),
                32'(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        end
        rst_n = 1'b1;
        idle_cycles(2);

        pay = '{8'h11, 8'h22, 8'hA5}; urun = 1'b0; n_take = 3;
        run_burst(-1);
        // back-to-back: req raised during the done cycle
        pay = '{8'h7F}; urun = 1'b1; n_take = 1;
        run_burst(-1);
        idle_cycles(1);
        pay.delete(); urun = 1'b1; n_take = 0;
        run_burst(-1);
        idle_cycles(2);

        for (int b = 0; b < 10; b++) begin
            int n;
            n = $urandom_range(1, 6);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            urun   = ($urandom_range(0, 2) == 0);
            n_take = urun ? $urandom_range(0, n - 1) : n;
            idle_cycles($urandom_range(0, 2));
            run_burst(-1);
        end
        idle_cycles(1);

`ifdef DPHY_SEQ_STATS_EN
        chk("stat_bursts_pre", 32'(stat_bursts), 32'(exp_bursts));
        chk("stat_underruns_pre", 32'(stat_underruns), 32'(exp_unders));
`endif

        // reset while the second payload byte is on the lane
        pay = '{8'h81, 8'h42, 8'h13, 8'hC4}; urun = 1'b0; n_take = 4;
        run_burst(int'(T_LPX + T_HS_PREPARE + T_HS_ZERO) + 2);
        exp_bursts = 0;
        exp_unders = 0;
        @(negedge byte_clk);
        chk("mid_reset", 32'(sample()), 32'(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        idle_cycles(3);

        pay = '{8'h01, 8'h80}; urun = 1'b0; n_take = 2;
        run_burst(-1);
        pay = '{8'hF0, 8'h0F, 8'h33}; urun = 1'b0; n_take = 3;
        run_burst(-1);
        idle_cycles(1);
        pay = '{8'hE1, 8'h2C}; urun = 1'b1; n_take = 1;
        run_burst(-1);
        idle_cycles(2);

`ifdef DPHY_SEQ_STATS_EN
        chk("stat_bursts", 32'(stat_bursts), 32'(exp_bursts));
        chk("stat_underruns", 32'(stat_underruns), 32'(exp_unders));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
